ws_frame_sched: RTL and testbench

Frame-level scheduler that sits between the UART receive byte stream and the WS2812 byte-serial line driver. It forwards one host frame of exactly 3·NUM_LEDS GRB bytes at a time and enforces the latch (reset) gap between frames. It aborts stalled host frames, and, when the host is silent, substitutes a locally generated test pattern so the strip never freezes.

---
 rtl/ws_frame_sched.sv | 217 +++++++++++++++++++++
 tb/tb_ws_frame_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_frame_sched.sv
// Frame scheduler between the UART byte stream and the WS2812 byte driver.
// Optional test-pattern fallback is compiled in when WS_PATTERN_EN is defined.
module ws_frame_sched #(
  parameter int NUM_LEDS     = 60,
  parameter int LATCH_CYCLES = 1024,
  parameter int STALL_CYCLES = 200,
  parameter int IDLE_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] host_data,
  input  logic       host_valid,
  input  logic       host_sof,
  output logic       host_ready,
  output logic [7:0] drv_data,
  output logic       drv_valid,
  input  logic       drv_ready,
  input  logic       drv_busy,
  output logic       frame_done,
  output logic       src_sel,
  output logic       underrun
);

  localparam int FRAME_BYTES = 3 * NUM_LEDS;
  localparam int BYTE_W      = $clog2(FRAME_BYTES + 1);
  localparam int GAP_W       = $clog2(LATCH_CYCLES + 1);
  localparam int STALL_W     = $clog2(STALL_CYCLES + 1);

  localparam logic [BYTE_W-1:0]  BYTE_LAST  = BYTE_W'(FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(LATCH_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LATCH  = 2'd0,
    S_SELECT = 2'd1,
    S_HOST   = 2'd2,
    S_PAT    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               frame_done_q, frame_done_d;
  logic               underrun_q, underrun_d;

`ifdef WS_PATTERN_EN
  localparam int LED_W  = $clog2(NUM_LEDS + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [LED_W-1:0]  LED_LAST  = LED_W'(NUM_LEDS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [1:0]        ch_q, ch_d;
  logic [7:0]        pat_frame_q, pat_frame_d;
  logic              src_sel_q;

  // Moving green ramp over a dim blue background; red channel stays dark.
  function automatic logic [7:0] pat_byte(input logic [7:0]       frame,
                                          input logic [LED_W-1:0] led,
                                          input logic [1:0]       ch);
    logic [7:0] led8;
    led8 = 8'(led);
    case (ch)
      2'd0:    pat_byte = frame + led8;
      2'd1:    pat_byte = 8'h00;
      default: pat_byte = 8'h10;
    endcase
  endfunction
`else
  logic unused_idle_cfg;
  assign unused_idle_cfg = (IDLE_TIMEOUT > 0);
`endif

  always_comb begin
    state_d      = state_q;
    gap_d        = '0;
    byte_d       = '0;
    stall_d      = '0;
    frame_done_d = 1'b0;
    underrun_d   = underrun_q;
    host_ready   = 1'b0;
    drv_valid    = 1'b0;
    drv_data     = 8'h00;
`ifdef WS_PATTERN_EN
    idle_d       = '0;
    led_d        = '0;
    ch_d         = '0;
    pat_frame_d  = pat_frame_q;
`endif

    case (state_q)
      S_LATCH: begin
        // Any driver activity restarts the full latch gap.
        if (drv_busy) begin
          gap_d = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_SELECT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_SELECT: begin
        // Non-sof bytes are drained to resynchronise; a sof byte is left
        // pending so that HOST forwards it as the first byte.
        host_ready = ~host_sof;
        if (host_valid && host_sof) begin
          state_d = S_HOST;
`ifdef WS_PATTERN_EN
        end else if (idle_q == IDLE_LAST) begin
          state_d = S_PAT;
        end else begin
          idle_d = idle_q + 1'b1;
`endif
        end
      end

      S_HOST: begin
        drv_data   = host_data;
        drv_valid  = host_valid;
        host_ready = drv_ready;
        byte_d     = byte_q;
        if (host_valid) begin
          stall_d = '0;
          if (drv_ready) begin
            if (byte_q == BYTE_LAST) begin
              frame_done_d = 1'b1;
              byte_d       = '0;
              state_d      = S_LATCH;
            end else begin
              byte_d = byte_q + 1'b1;
            end
          end
        end else if (stall_q == STALL_LAST) begin
          underrun_d = 1'b1;
          byte_d     = '0;
          state_d    = S_LATCH;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end

`ifdef WS_PATTERN_EN
      S_PAT: begin
        drv_valid = 1'b1;
        drv_data  = pat_byte(pat_frame_q, led_q, ch_q);
        led_d     = led_q;
        ch_d      = ch_q;
        if (drv_ready) begin
          if (ch_q == 2'd2) begin
            ch_d = 2'd0;
            if (led_q == LED_LAST) begin
              frame_done_d = 1'b1;
              pat_frame_d  = pat_frame_q + 8'd1;
              led_d        = '0;
              state_d      = S_LATCH;
            end else begin
              led_d = led_q + 1'b1;
            end
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end
      end
`endif

      default: state_d = S_LATCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LATCH;
      gap_q        <= '0;
      byte_q       <= '0;
      stall_q      <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      byte_q       <= byte_d;
      stall_q      <= stall_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

`ifdef WS_PATTERN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q      <= '0;
      led_q       <= '0;
      ch_q        <= '0;
      pat_frame_q <= 8'h00;
      src_sel_q   <= 1'b0;
    end else begin
      idle_q      <= idle_d;
      led_q       <= led_d;
      ch_q        <= ch_d;
      pat_frame_q <= pat_frame_d;
      src_sel_q   <= (state_d == S_PAT);
    end
  end

  assign src_sel = src_sel_q;
`else
  assign src_sel = 1'b0;
`endif

  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_ws_frame_sched.sv
// Scoreboard bench for ws_frame_sched: directed host frames, resync, stall,
// latch-gap, reset and (with WS_PATTERN_EN) pattern-fallback scenarios.
module tb_ws_frame_sched;

  localparam int NL = 2;
  localparam int LC = 16;
  localparam int SC = 8;
  localparam int IT = 32;
  localparam int FB = 3 * NL;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] host_data;
  logic       host_valid;
  logic       host_sof;
  logic       host_ready;
  logic [7:0] drv_data;
  logic       drv_valid;
  logic       drv_ready;
  logic       drv_busy;
  logic       frame_done;
  logic       src_sel;
  logic       underrun;

  ws_frame_sched #(
    .NUM_LEDS    (NL),
    .LATCH_CYCLES(LC),
    .STALL_CYCLES(SC),
    .IDLE_TIMEOUT(IT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host_data (host_data),
    .host_valid(host_valid),
    .host_sof  (host_sof),
    .host_ready(host_ready),
    .drv_data  (drv_data),
    .drv_valid (drv_valid),
    .drv_ready (drv_ready),
    .drv_busy  (drv_busy),
    .frame_done(frame_done),
    .src_sel   (src_sel),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       src;
    logic [7:0] d;
  } exp_t;

  exp_t expq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_seen   = 0;
  int   done_exp    = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Monitor: every driver handshake pops one expected byte.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (drv_valid === 1'b1 && drv_ready === 1'b1) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: got %0h (src %0b), expected none",
                   drv_data, src_sel);
        end else begin
          e = expq.pop_front();
          chk("drv_data", {24'h0, drv_data}, {24'h0, e.d});
          chk("src_sel", {31'h0, src_sel}, {31'h0, e.src});
        end
      end
      if (frame_done === 1'b1) done_seen++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  // Present one byte and hold it until accepted; returns cycles spent waiting.
  task automatic send_byte(input logic [7:0] d, input logic sof, output int waited);
    logic r;
    bit   fin;
    host_data  = d;
    host_sof   = sof;
    host_valid = 1'b1;
    waited     = 0;
    fin        = 1'b0;
    while (!fin) begin
      @(negedge clk);
      r = host_ready;
      @(posedge clk);
      #1;
      if (r) begin
        fin = 1'b1;
      end else begin
        waited++;
        if (waited > 400) begin
          chk("send_timeout", 32'h0, 32'h1);
          fin = 1'b1;
        end
      end
    end
    host_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int wait_exp);
    int w;
    for (int k = 0; k < FB; k++) expq.push_back({1'b0, base + 8'(k)});
    for (int k = 0; k < FB; k++) begin
      send_byte(base + 8'(k), (k == 0), w);
      if (k == 0) chk("first_wait", w, wait_exp);
    end
    host_valid = 1'b0;
    done_exp++;
  endtask

  initial begin
    int w;
    rst        = 1'b1;
    host_data  = 8'h00;
    host_valid = 1'b0;
    host_sof   = 1'b0;
    drv_ready  = 1'b1;
    drv_busy   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_host_ready", {31'h0, host_ready}, 32'h0);
    chk("rst_drv_valid", {31'h0, drv_valid}, 32'h0);
    chk("rst_drv_data", {24'h0, drv_data}, 32'h0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    chk("rst_src_sel", {31'h0, src_sel}, 32'h0);
    chk("rst_underrun", {31'h0, underrun}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back host frames: full latch gap plus one SELECT cycle between.
    send_frame(8'h01, LC + 1);
    send_frame(8'h11, LC + 1);

    // Resync: stray non-sof bytes are drained in SELECT and never forwarded.
    send_byte(8'hAA, 1'b0, w);
    chk("discard_aa_wait", w, LC);
    send_byte(8'hBB, 1'b0, w);
    chk("discard_bb_wait", w, 0);
    host_valid = 1'b0;
    send_frame(8'h21, 1);

    // Driver busy 40 cycles, then idle 8, one busy glitch, then a full gap.
    fork
      begin
        drv_busy = 1'b1;
        repeat (40) @(posedge clk);
        #1 drv_busy = 1'b0;
        repeat (8) @(posedge clk);
        #1 drv_busy = 1'b1;
        @(posedge clk);
        #1 drv_busy = 1'b0;
      end
      send_frame(8'h31, 40 + 8 + 1 + LC + 1);
    join

    // Host stall mid-frame.
    expq.push_back({1'b0, 8'h41});
    expq.push_back({1'b0, 8'h42});
    expq.push_back({1'b0, 8'h43});
    send_byte(8'h41, 1'b1, w);
    chk("stall_first_wait", w, LC + 1);
    send_byte(8'h42, 1'b0, w);
    send_byte(8'h43, 1'b0, w);
    host_valid = 1'b0;
    repeat (SC) @(negedge clk);
    chk("stall_pre_underrun", {31'h0, underrun}, 32'h0);
    chk("stall_pre_ready", {31'h0, host_ready}, 32'h1);
    @(negedge clk);
    chk("stall_underrun", {31'h0, underrun}, 32'h1);
    chk("stall_latch_ready", {31'h0, host_ready}, 32'h0);
    send_byte(8'h44, 1'b0, w);
    send_byte(8'h45, 1'b0, w);
    send_byte(8'h46, 1'b0, w);
    send_frame(8'h51, 1);
    chk("underrun_sticky", {31'h0, underrun}, 32'h1);

    // Reset in the middle of a host frame.
    expq.push_back({1'b0, 8'h61});
    expq.push_back({1'b0, 8'h62});
    send_byte(8'h61, 1'b1, w);
    chk("rstmid_first_wait", w, LC + 1);
    send_byte(8'h62, 1'b0, w);
    rst        = 1'b1;
    host_valid = 1'b0;
    @(posedge clk);
    #1;
    host_valid = 1'b1;
    host_data  = 8'h63;
    host_sof   = 1'b0;
    @(negedge clk);
    chk("rstmid_host_ready", {31'h0, host_ready}, 32'h0);
    chk("rstmid_drv_valid", {31'h0, drv_valid}, 32'h0);
    chk("rstmid_underrun", {31'h0, underrun}, 32'h0);
    chk("rstmid_frame_done", {31'h0, frame_done}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_byte(8'h63, 1'b0, w);
    send_byte(8'h64, 1'b0, w);
    send_byte(8'h65, 1'b0, w);
    send_byte(8'h66, 1'b0, w);
    send_frame(8'h71, 1);

`ifdef WS_PATTERN_EN
    // Host silent: two pattern frames, with backpressure at the first byte.
    drv_ready = 1'b0;
    expq.push_back({1'b1, 8'h00});
    expq.push_back({1'b1, 8'h00});
    expq.push_back({1'b1, 8'h10});
    expq.push_back({1'b1, 8'h01});
    expq.push_back({1'b1, 8'h00});
    expq.push_back({1'b1, 8'h10});
    expq.push_back({1'b1, 8'h01});
    expq.push_back({1'b1, 8'h00});
    expq.push_back({1'b1, 8'h10});
    expq.push_back({1'b1, 8'h02});
    expq.push_back({1'b1, 8'h00});
    expq.push_back({1'b1, 8'h10});
    done_exp += 2;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (src_sel !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("pat_enter", {31'h0, src_sel}, 32'h1);
      for (int k = 0; k < 3; k++) begin
        chk("pat_hold_valid", {31'h0, drv_valid}, 32'h1);
        chk("pat_hold_data", {24'h0, drv_data}, 32'h0);
        @(negedge clk);
      end
      @(posedge clk);
      #1 drv_ready = 1'b1;
      n = 0;
      while (expq.size() != 0 && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    chk("frame_done_count", done_seen, done_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
